// File: rtl/price_fmt_pkg.sv
// Shared types and constants for the price line formatter: FSM states,
// ASCII codes and geometry helpers for slicing packed entries.
package price_fmt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_EMIT,
    S_DONE
  } state_e;

  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_ZERO  = 7'h30;
  localparam logic [6:0] CH_X     = 7'h78;
  localparam logic [6:0] CH_T     = 7'h54;
  localparam logic [6:0] CH_L     = 7'h4C;
  localparam logic [6:0] CH_EQ    = 7'h3D;

  function automatic int line_len(input int digits);
    return 3 + digits;
  endfunction

  // Item 0 sits in the MSB slice, so higher indices move toward bit 0.
  function automatic int entry_lsb(input int idx, input int n_items, input int entry_w);
    return (n_items - 1 - idx) * entry_w;
  endfunction

endpackage

// File: rtl/price_line_formatter_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter; result is valid once done
// pulses, which happens in the BITS-th cycle after start is taken.
module bin2bcd_seq #(
  parameter int BITS   = 20,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [BITS-1:0]       bin_i,
  output logic                  done_o,
  output logic [DIGITS*4-1:0]   bcd_o
);

  localparam int CW = $clog2(BITS + 1);

  logic [BITS-1:0]     sr_q, sr_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                run_q, run_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    sr_d  = sr_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (run_q) begin
      bcd_d = {adj[DIGITS*4-2:0], sr_q[BITS-1]};
      sr_d  = {sr_q[BITS-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(BITS - 1)) run_d = 1'b0;
    end else if (start_i) begin
      sr_d  = bin_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end
  end

  assign done_o = run_q && (cnt_q == CW'(BITS - 1));
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/price_line_formatter.sv
// Walks a snapshot of (count, price) entries plus a total and streams one
// formatted ASCII line per entry, a character per valid/ready beat.
module price_line_formatter
  import price_fmt_pkg::*;
#(
  parameter int N_ITEMS    = 12,
  parameter int CNT_W      = 4,
  parameter int PRICE_W    = 16,
  parameter int DIGITS     = 7,
  parameter int BLANK_ZERO = 1
) (
  input  logic                                 CLK,
  input  logic                                 RESET_N,
  input  logic                                 start,
  input  logic [N_ITEMS*(CNT_W+PRICE_W)-1:0]   numbers,
  input  logic [CNT_W+PRICE_W-1:0]             total_price,
  output logic                                 wr_valid,
  input  logic                                 wr_ready,
  output logic [$clog2(N_ITEMS+1)-1:0]         wr_line,
  output logic [$clog2(line_len(DIGITS))-1:0]  wr_col,
  output logic [6:0]                           wr_char,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ENTRY_W  = CNT_W + PRICE_W;
  localparam int LINE_LEN = line_len(DIGITS);
  localparam int LINE_W   = $clog2(N_ITEMS + 1);
  localparam int COL_W    = $clog2(LINE_LEN);

  state_e                     state_q, state_d;
  logic [LINE_W-1:0]          line_q, line_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [N_ITEMS*ENTRY_W-1:0] numbers_q, numbers_d;
  logic [ENTRY_W-1:0]         total_q, total_d;

  logic                       is_total, blank, conv_start, conv_done;
  logic [ENTRY_W-1:0]         entry, value;
  logic [CNT_W-1:0]           cnt;
  logic [PRICE_W-1:0]         price;
  logic [6:0]                 tens, ones, ch;
  logic [DIGITS*4-1:0]        bcd;
  logic [3:0]                 dig;
  int                         k;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      col_q     <= '0;
      numbers_q <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      col_q     <= col_d;
      numbers_q <= numbers_d;
      total_q   <= total_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    col_d     = col_q;
    numbers_d = numbers_q;
    total_d   = total_q;
    case (state_q)
      S_IDLE: if (start) begin
        numbers_d = numbers;
        total_d   = total_price;
        line_d    = '0;
        col_d     = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: state_d = S_CONV;
      S_CONV: if (conv_done) state_d = S_EMIT;
      S_EMIT: if (wr_ready) begin
        if (col_q == COL_W'(LINE_LEN - 1)) begin
          col_d = '0;
          if (is_total) begin
            state_d = S_DONE;
          end else begin
            line_d  = line_q + LINE_W'(1);
            state_d = S_LOAD;
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_valid   = (state_q == S_EMIT);
    busy       = (state_q == S_LOAD) || (state_q == S_CONV) || (state_q == S_EMIT);
    done       = (state_q == S_DONE);
    conv_start = (state_q == S_LOAD);
    wr_line    = line_q;
    wr_col     = col_q;
    wr_char    = (state_q == S_EMIT) ? ch : 7'd0;
  end

  // The total line reuses slot 0 only so the slice index stays in range.
  assign is_total = (line_q == LINE_W'(N_ITEMS));
  assign entry    = numbers_q[entry_lsb(is_total ? 0 : int'(line_q), N_ITEMS, ENTRY_W) +: ENTRY_W];
  assign cnt      = entry[ENTRY_W-1 -: CNT_W];
  assign price    = entry[PRICE_W-1:0];
  assign value    = is_total ? total_q : ENTRY_W'(cnt) * ENTRY_W'(price);
  assign blank    = (BLANK_ZERO != 0) && !is_total && (cnt == '0);

  always_comb begin
    ones = 7'(cnt);
    tens = 7'd0;
    for (int i = 0; i < 6; i++) begin
      if (ones >= 7'd10) begin
        ones = ones - 7'd10;
        tens = tens + 7'd1;
      end
    end
  end

  always_comb begin
    ch  = CH_SPACE;
    k   = 0;
    dig = '0;
    if (blank) begin
      ch = CH_SPACE;
    end else if (col_q == COL_W'(0)) begin
      ch = is_total ? CH_T : ((tens == 7'd0) ? CH_SPACE : CH_ZERO + tens);
    end else if (col_q == COL_W'(1)) begin
      ch = is_total ? CH_L : CH_ZERO + ones;
    end else if (col_q == COL_W'(2)) begin
      ch = is_total ? CH_EQ : CH_X;
    end else begin
      // Show a digit once it or any more significant digit is nonzero.
      k   = LINE_LEN - 1 - int'(col_q);
      dig = bcd[4*k +: 4];
      if (k == 0 || (bcd >> (4*k)) != '0) ch = CH_ZERO + {3'b000, dig};
    end
  end

  bin2bcd_seq #(
    .BITS   (ENTRY_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .start_i (conv_start),
    .bin_i   (value),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

endmodule

// File: tb/tb_price_line_formatter.sv
// Bench for price_line_formatter: table vectors plus random frames checked
// against a string-formatting model of each expected line.
module tb_price_line_formatter;

  localparam int N  = 12;
  localparam int EW = 20;
  localparam int LL = 10;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            start = 1'b0;
  logic            wr_ready = 1'b0;
  logic [N*EW-1:0] numbers = '0;
  logic [EW-1:0]   total_price = '0;
  logic            wr_valid, busy, done;
  logic [3:0]      wr_line, wr_col;
  logic [6:0]      wr_char;

  always #5 CLK = ~CLK;

  price_line_formatter dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .numbers(numbers),
    .total_price(total_price), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_line(wr_line), .wr_col(wr_col), .wr_char(wr_char),
    .busy(busy), .done(done)
  );

  typedef struct {
    int    cnt;
    int    price;
    int    total;
    bit    rnd;
    string l0;
    string lt;
  } vec_t;

  vec_t vt[8];
  int   total_cnt = 0;
  int   bad_cnt = 0;
  int   s_cnt[N];
  int   s_price[N];
  int   s_total;
  byte  got[N+1][LL];
  int   nbeats, order_bad, ndone, busy_cyc, done_cyc;

  task automatic chk(input string name, input longint g, input longint e);
    total_cnt++;
    if (g != e) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, g, e);
    end
  endtask

  task automatic chk_s(input string name, input string g, input string e);
    total_cnt++;
    if (g != e) begin
      bad_cnt++;
      $display("FAIL %s: got '%s' expected '%s'", name, g, e);
    end
  endtask

  function automatic string model_line(input int l);
    if (l == N) return {"TL=", $sformatf("%7d", s_total)};
    if (s_cnt[l] == 0) return "          ";
    return $sformatf("%2dx%7d", s_cnt[l], s_cnt[l] * s_price[l]);
  endfunction

  function automatic string got_line(input int l);
    string s = "";
    for (int c = 0; c < LL; c++) s = {s, $sformatf("%c", got[l][c])};
    return s;
  endfunction

  function automatic logic [N*EW-1:0] pack_numbers();
    logic [N*EW-1:0] r = '0;
    for (int i = 0; i < N; i++) r[(N-1-i)*EW +: EW] = {4'(s_cnt[i]), 16'(s_price[i])};
    return r;
  endfunction

  task automatic fill(input int c0, input int p0, input int tot, input bit rnd);
    s_cnt[0]   = c0;
    s_price[0] = p0;
    for (int i = 1; i < N; i++) begin
      s_cnt[i]   = rnd ? int'($urandom_range(0, 15)) : 0;
      s_price[i] = rnd ? int'($urandom_range(0, 65535)) : 0;
    end
    s_total = tot;
  endtask

  // Called just after a rising edge; drives start and then monitors a frame.
  task automatic run_frame(input int mode, input bit poke, input string tag);
    bit         prev_stall = 1'b0;
    logic [3:0] pl = '0, pc = '0;
    logic [6:0] pch = '0;
    for (int l = 0; l <= N; l++)
      for (int c = 0; c < LL; c++) got[l][c] = 8'h3F;
    nbeats = 0; order_bad = 0; ndone = 0; busy_cyc = -1; done_cyc = -1;
    numbers     = pack_numbers();
    total_price = EW'(s_total);
    start       = 1'b1;
    wr_ready    = (mode == 0);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge CLK);
      if (busy && busy_cyc < 0) busy_cyc = cyc;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk({tag, " busy low with done"}, busy, 0);
      end
      if (prev_stall)
        chk({tag, " stall hold"}, {wr_valid, wr_line, wr_col, wr_char}, {1'b1, pl, pc, pch});
      prev_stall = wr_valid && !wr_ready;
      pl = wr_line; pc = wr_col; pch = wr_char;
      if (wr_valid && wr_ready) begin
        if (nbeats < (N+1)*LL) begin
          if (int'(wr_line) != nbeats / LL || int'(wr_col) != nbeats % LL) order_bad++;
          else got[wr_line][wr_col] = {1'b0, wr_char};
        end
        nbeats++;
        if (poke && int'(wr_line) == N && int'(wr_col) == LL-1) start = 1'b1;
      end
      @(posedge CLK);
      #1;
      start = 1'b0;
      if (poke && cyc == 2) begin
        numbers     = ~numbers;
        total_price = EW'($urandom);
      end
      if (poke && (cyc == 60 || cyc == 200)) start = 1'b1;
      if (mode == 1) wr_ready = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      if (done_cyc >= 0 && cyc >= done_cyc + 20) break;
    end
    chk({tag, " done count"}, ndone, 1);
    chk({tag, " beats"}, nbeats, (N+1)*LL);
    chk({tag, " beat order"}, order_bad, 0);
    if (mode == 0) chk({tag, " busy-to-done cycles"}, done_cyc - busy_cyc, 403);
    for (int l = 0; l <= N; l++)
      chk_s($sformatf("%s line%0d", tag, l), got_line(l), model_line(l));
  endtask

  initial begin
    vt[0] = '{0,     0,     0,       1'b0, "          ", "TL=      0"};
    vt[1] = '{3,     1250,  0,       1'b0, " 3x   3750", "TL=      0"};
    vt[2] = '{15,    65535, 1048575, 1'b1, "15x 983025", "TL=1048575"};
    vt[3] = '{9,     9999,  12345,   1'b1, " 9x  89991", "TL=  12345"};
    vt[4] = '{12,    5000,  7,       1'b1, "12x  60000", "TL=      7"};
    vt[5] = '{1,     0,     100000,  1'b1, " 1x      0", "TL= 100000"};
    vt[6] = '{10,    1,     99,      1'b1, "10x     10", "TL=     99"};
    vt[7] = '{0,     500,   1000000, 1'b1, "          ", "TL=1000000"};

    #12;
    chk("reset state", {wr_valid, busy, done, wr_line, wr_col, wr_char}, 0);
    @(negedge CLK) RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // Reset asserted while a line is being emitted.
    fill(3, 1250, 5, 1'b1);
    numbers = pack_numbers();
    start = 1'b1; wr_ready = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (30) @(posedge CLK);
    #2;
    chk("pre-reset valid", wr_valid, 1);
    RESET_N = 1'b0;
    #1;
    chk("mid-run reset outputs", {wr_valid, busy, done, wr_line, wr_col, wr_char}, 0);
    @(negedge CLK) RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    run_frame(0, 1'b0, "after_reset");

    for (int i = 0; i < 8; i++) begin
      fill(vt[i].cnt, vt[i].price, vt[i].total, vt[i].rnd);
      run_frame(0, 1'b0, $sformatf("vec%0d", i));
      chk_s($sformatf("vec%0d table line0", i), got_line(0), vt[i].l0);
      chk_s($sformatf("vec%0d table total", i), got_line(N), vt[i].lt);
    end

    fill(int'($urandom_range(1, 15)), int'($urandom_range(0, 65535)),
         int'($urandom_range(0, 1048575)), 1'b1);
    run_frame(1, 1'b0, "backpressure");

    wr_ready = 1'b1;
    fill(int'($urandom_range(1, 15)), int'($urandom_range(0, 65535)),
         int'($urandom_range(0, 1048575)), 1'b1);
    run_frame(0, 1'b1, "start_while_busy");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/price_line_formatter.md
Name: price_line_formatter

Overview:
- Sequential successor to the fixed 12-slot combinational price-to-digit path.
- On `start`, it snapshots N_ITEMS packed (count, unit price) entries plus one total value and walks them one line at a time.
- For each line it forms count×price, converts the result to decimal with a sequential double-dabble, and emits a formatted ASCII text line, one character per valid/ready beat.
- It feeds the character-buffer/pixel-writer stage, so the combinational per-slot converters are no longer needed.

Parameters:
- N_ITEMS, 12, number of item lines; the total line is emitted after them as line N_ITEMS.
- CNT_W, 4, item count width; must be ≤6 so the count fits in 2 decimal digits.
- PRICE_W, 16, unit price width.
- DIGITS, 7, value field width in decimal digits; must satisfy 10^DIGITS > 2^(CNT_W+PRICE_W)-1.
- BLANK_ZERO, 1, when 1 an item line with count==0 is emitted as all spaces.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to format all lines; ignored while busy.
- numbers  in  N_ITEMS*(CNT_W+PRICE_W)  packed entries; item 0 occupies the MSB slice; within each entry, count is in the top CNT_W bits.
- total_price  in  CNT_W+PRICE_W  total value, displayed directly with no multiply.
- wr_valid  out  1  character beat valid.
- wr_ready  in  1  downstream accepts the beat.
- wr_line  out  $clog2(N_ITEMS+1)  line index of the current character.
- wr_col  out  $clog2(LINE_LEN)  column index; LINE_LEN = 3+DIGITS.
- wr_char  out  7  ASCII code.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last character is accepted.

Behaviour:
- Reset (asynchronous, RESET_N=0) clears all outputs and state: wr_valid, busy and done are 0; wr_line, wr_col and wr_char are 0. State returns to IDLE immediately; a line in flight is dropped.
- States: IDLE → LOAD → CONV → EMIT → (LOAD of the next line | DONE) → IDLE.
- IDLE: `start` latches `numbers` and `total_price` into snapshot registers, sets busy, and selects line 0. Later input changes do not affect the run.
- LOAD (1 cycle):
  - Item lines: value = count×price, width CNT_W+PRICE_W, unsigned, never overflows.
  - Total line: value = total_price.
  - Start bin2bcd_seq.
- CONV: exactly CNT_W+PRICE_W cycles. It always runs, including blank lines, so line timing is uniform.
- EMIT: columns 0..LINE_LEN-1 are emitted in ascending order, one beat per handshake. wr_valid stays high, and wr_line/wr_col/wr_char stay stable, until wr_ready=1. A beat transfers only on wr_valid&wr_ready.
- Item line format:
  - col0-1: count in decimal, with the leading zero shown as space (e.g. " 3").
  - col2: 'x' (0x78).
  - col3..: value right-justified; leading zeros shown as space (0x20); the last digit is always shown, so zero prints as "0".
- Total line format: col0='T' (0x54), col1='L' (0x4C), col2='=' (0x3D), then the value field formatted as above.
- Blanking: if BLANK_ZERO=1 and count==0, all LINE_LEN characters are spaces. The total line is never blanked.
- Timing with wr_ready held high: each line takes 1+(CNT_W+PRICE_W)+LINE_LEN cycles (31 at defaults). done pulses in the cycle after the final beat; busy falls in that same cycle.
- start while busy, including in the same cycle as the last beat, is ignored.
- wr_ready while wr_valid=0 has no effect.

Decomposition:
- Package price_fmt_pkg contains:
  - the state enum;
  - ASCII constants (SPACE, ZERO, X, T, L, EQ);
  - a LINE_LEN function;
  - the entry-slice helper.
- Sub-module bin2bcd_seq: a parametrised (BITS, DIGITS) shift-add-3 converter with a start/done handshake, producing a DIGITS×4 BCD output. It is reusable by the total/VGA path.
- The 2-digit count split (value≥10 compare-subtract chain) is combinational inside the top module.

Test Plan:
- Reset: assert RESET_N=0 mid-run → same cycle wr_valid=0, busy=0, done=0. After release, a new start restarts from line 0, col 0.
- All entries 0, total 0, wr_ready=1:
  - lines 0-11 are 10 spaces each;
  - line 12 is "TL=      0";
  - done occurs 403 cycles after the busy rise.
- Item 0 count=3 price=1250, others 0 → line 0 is " 3x   3750"; lines 1-11 are blank.
- Maximum values: count=15 price=65535 → "15x 983025"; total_price=0xFFFFF → "TL=1048575".
- Backpressure: wr_ready held low 5 cycles, then toggling randomly → wr_valid/line/col/char stay stable while stalled; 130 beats in order; none dropped or duplicated.
- start pulsed while busy and in the same cycle as the last beat → ignored; exactly one done; snapshot unaffected by numbers changing mid-run.
